// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory stage: FSM states, lane count, address translation.
// Latency: n/a (declarations only); backpressure: n/a.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DMEM_DATA_W = 32;
    localparam int BYTE_LANES  = DMEM_DATA_W / 8;

    // Byte offset from the window base, shifted down to a word index.
    function automatic logic [31:0] word_idx(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> $clog2(BYTE_LANES);
    endfunction

endpackage

// File: rtl/dmem_addr_xlate.sv
// Combinational byte-address to word-index translation with range and alignment fault detection.
// Latency: 0 cycles; backpressure: none (pure function of i_addr).
module dmem_addr_xlate
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 1024,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [AW-1:0]     o_idx,
    output logic              o_fault
);

    logic [31:0] w_idx_full;
    logic        w_below;
    logic        w_over;
    logic        w_misalign;

    assign w_idx_full = word_idx(32'(i_addr), 32'(BASE_ADDR));
    assign w_below    = i_addr < ADDR_W'(BASE_ADDR);
    // Any index bit above the array width means the word lies past the end.
    assign w_over     = |w_idx_full[31:AW];
    assign w_misalign = |i_addr[1:0];

    assign o_idx   = w_idx_full[AW-1:0];
    assign o_fault = w_below | w_over | w_misalign;

endmodule

// File: rtl/dmem_stage_ctrl.sv
// MEM-stage data memory: programmable-latency read/write with fault flagging; DMEM_BYTE_MASK_EN adds i_be.
// Latency: LATENCY cycles accept->o_done; backpressure: o_stall holds upstream from accept until DONE.
module dmem_stage_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 1024,
    parameter int LATENCY   = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rd,
    input  logic                i_wr,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
`ifdef DMEM_BYTE_MASK_EN
    input  logic [DATA_W/8-1:0] i_be,
`endif
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_done,
    output logic                o_stall,
    output logic                o_err
);

    localparam int AW = $clog2(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [AW-1:0]       r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_op_rd;
    logic                r_op_wr;
    logic                r_fault;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_req;
    logic                w_accept;
    logic                w_stall;
    logic                w_enter_done;
    logic [AW-1:0]       w_idx;
    logic                w_range_fault;
    logic                w_fault_in;
    logic [AW-1:0]       w_cur_idx;
    logic [DATA_W-1:0]   w_cur_wdata;
    logic                w_cur_rd;
    logic                w_cur_wr;
    logic                w_cur_fault;
    logic                w_commit_wr;
    logic                w_read;

    dmem_addr_xlate #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_xlate (
        .i_addr  (i_addr),
        .o_idx   (w_idx),
        .o_fault (w_range_fault)
    );

    assign w_req      = i_rd | i_wr;
    assign w_accept   = (r_state == IDLE) & w_req;
    assign w_fault_in = w_range_fault | (i_rd & i_wr);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stall      = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        w_state_nxt  = DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_nxt  = WAIT;
                    end
                end
            end
            WAIT: begin
                w_stall   = 1'b1;
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = DONE;
                    w_enter_done = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // With LATENCY==1 the accept edge is also the completion edge, so use live inputs in IDLE.
    assign w_cur_idx   = (r_state == IDLE) ? w_idx      : r_idx;
    assign w_cur_wdata = (r_state == IDLE) ? i_wdata    : r_wdata;
    assign w_cur_rd    = (r_state == IDLE) ? i_rd       : r_op_rd;
    assign w_cur_wr    = (r_state == IDLE) ? i_wr       : r_op_wr;
    assign w_cur_fault = (r_state == IDLE) ? w_fault_in : r_fault;

    assign w_commit_wr = w_enter_done & w_cur_wr & ~w_cur_fault;
    assign w_read      = w_enter_done & w_cur_rd;

`ifdef DMEM_BYTE_MASK_EN
    logic [DATA_W/8-1:0] r_be;
    logic [DATA_W/8-1:0] w_cur_be;

    assign w_cur_be = (r_state == IDLE) ? i_be : r_be;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_be <= '0;
        end else if (w_accept) begin
            r_be <= i_be;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_commit_wr) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (w_cur_be[i]) begin
                    r_mem[w_cur_idx][8*i +: 8] <= w_cur_wdata[8*i +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (w_commit_wr) begin
            r_mem[w_cur_idx] <= w_cur_wdata;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_op_rd <= 1'b0;
            r_op_wr <= 1'b0;
            r_fault <= 1'b0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_wdata <= i_wdata;
                r_op_rd <= i_rd;
                r_op_wr <= i_wr;
                r_fault <= w_fault_in;
            end
            if (w_read) begin
                r_rdata <= w_cur_fault ? '0 : r_mem[w_cur_idx];
            end
            r_done <= w_enter_done;
            r_err  <= w_enter_done & w_cur_fault;
        end
    end

    assign o_rdata = r_rdata;
    assign o_done  = r_done;
    assign o_stall = w_stall;
    assign o_err   = r_err;

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
// Scoreboard bench for dmem_stage_ctrl: one LATENCY=1 and one LATENCY=4 instance, directed vectors.
module tb_dmem_stage_ctrl;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd    [2];
    logic        wr    [2];
    logic [15:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        done  [2];
    logic        stall [2];
    logic        err   [2];
    string       tag   [2];
`ifdef DMEM_BYTE_MASK_EN
    logic [3:0]  be    [2];
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 clk = ~clk;

    dmem_stage_ctrl #(.LATENCY(1)) u_l1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_rd    (rd[0]),
        .i_wr    (wr[0]),
        .i_addr  (addr[0]),
        .i_wdata (wdata[0]),
`ifdef DMEM_BYTE_MASK_EN
        .i_be    (be[0]),
`endif
        .o_rdata (rdata[0]),
        .o_done  (done[0]),
        .o_stall (stall[0]),
        .o_err   (err[0])
    );

    dmem_stage_ctrl #(.LATENCY(4)) u_l4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_rd    (rd[1]),
        .i_wr    (wr[1]),
        .i_addr  (addr[1]),
        .i_wdata (wdata[1]),
`ifdef DMEM_BYTE_MASK_EN
        .i_be    (be[1]),
`endif
        .o_rdata (rdata[1]),
        .o_done  (done[1]),
        .o_stall (stall[1]),
        .o_err   (err[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every done pulse consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (done[d] === 1'b1) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk($sformatf("spurious_done_dut%0d", d), 32'(done[d]), 32'd0);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk({tag[d], "_err"}, 32'(err[d]), 32'(e.err));
                    if (e.chk_rd) chk({tag[d], "_rdata"}, rdata[d], e.rdata);
                end
            end
        end
    end

    task automatic push_exp(input int d, input string nm, input logic e_err,
                            input logic e_chk, input logic [31:0] e_rd);
        exp_t e;
        e = '{e_err, e_chk, e_rd};
        tag[d] = nm;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after an edge with the DUT idle.
    task automatic issue(input int d, input string nm, input logic r, input logic w,
                         input logic [15:0] a, input logic [31:0] wd,
                         input logic e_err, input logic e_chk, input logic [31:0] e_rd);
        int cyc;
        push_exp(d, nm, e_err, e_chk, e_rd);
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (done[d] !== 1'b1 && cyc < 40);
        chk({nm, "_latency"}, 32'(cyc), (d == 0) ? 32'd1 : 32'd4);
        if (done[d] !== 1'b1) begin
            if (d == 0) void'(q0.pop_back());
            else        void'(q1.pop_back());
        end
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; tag[d] = "";
`ifdef DMEM_BYTE_MASK_EN
            be[d] = 4'hF;
`endif
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_done%0d",  d), 32'(done[d]),  32'd0);
            chk($sformatf("rst_stall%0d", d), 32'(stall[d]), 32'd0);
            chk($sformatf("rst_err%0d",   d), 32'(err[d]),   32'd0);
            chk($sformatf("rst_rdata%0d", d), rdata[d],      32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LATENCY=1: basic write/read
        issue(0, "wr1024", 0, 1, 16'd1024, 32'hDEADBEEF, 0, 0, 0);
        issue(0, "rd1024", 1, 0, 16'd1024, 32'h0,        0, 1, 32'hDEADBEEF);
        issue(0, "wr1028", 0, 1, 16'd1028, 32'h12345678, 0, 0, 0);
        issue(0, "wr2044", 0, 1, 16'd2044, 32'h5A5A5A5A, 0, 0, 0);
        issue(0, "rd1028", 1, 0, 16'd1028, 32'h0,        0, 1, 32'h12345678);

        // Range/alignment faults on reads and writes
        issue(0, "rd1023", 1, 0, 16'd1023, 32'h0, 1, 1, 32'h0);
        issue(0, "rd2044", 1, 0, 16'd2044, 32'h0, 0, 1, 32'h5A5A5A5A);
        issue(0, "rd1026", 1, 0, 16'd1026, 32'h0, 1, 1, 32'h0);
        issue(0, "rd1028b", 1, 0, 16'd1028, 32'h0, 0, 1, 32'h12345678);
        issue(0, "rd2048", 1, 0, 16'd2048, 32'h0, 1, 1, 32'h0);
        issue(0, "wr1023", 0, 1, 16'd1023, 32'h11111111, 1, 0, 0);
        issue(0, "wr1026", 0, 1, 16'd1026, 32'h22222222, 1, 0, 0);
        issue(0, "wr2048", 0, 1, 16'd2048, 32'h33333333, 1, 0, 0);
        issue(0, "rd1024_after_flt", 1, 0, 16'd1024, 32'h0, 0, 1, 32'hDEADBEEF);
        issue(0, "rd2044_after_flt", 1, 0, 16'd2044, 32'h0, 0, 1, 32'h5A5A5A5A);

        // rd and wr together
        issue(0, "wr1032", 0, 1, 16'd1032, 32'hAAAA5555, 0, 0, 0);
        issue(0, "rdwr1032", 1, 1, 16'd1032, 32'h0BADF00D, 1, 1, 32'h0);
        issue(0, "rd1032", 1, 0, 16'd1032, 32'h0, 0, 1, 32'hAAAA5555);

        // LATENCY=4: stall profile
        issue(1, "l4_wr1028", 0, 1, 16'd1028, 32'hCAFEF00D, 0, 0, 0);
        push_exp(1, "l4_stall_rd", 0, 1, 32'hCAFEF00D);
        rd[1] = 1'b1; addr[1] = 16'd1028;
        #1;
        chk("l4_stall_accept", 32'(stall[1]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("l4_stall_wait%0d", k), 32'(stall[1]), 32'd1);
            chk($sformatf("l4_done_early%0d", k), 32'(done[1]), 32'd0);
        end
        @(posedge clk); #1;
        chk("l4_done_4th_edge", 32'(done[1]), 32'd1);
        chk("l4_stall_in_done", 32'(stall[1]), 32'd0);
        rd[1] = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a write
        wr[1] = 1'b1; addr[1] = 16'd1028; wdata[1] = 32'h0BADBAD0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_wr_stall", 32'(stall[1]), 32'd1);
        rst_n = 1'b0;
        wr[1] = 1'b0;
        #1;
        chk("arst_done",   32'(done[1]),  32'd0);
        chk("arst_err",    32'(err[1]),   32'd0);
        chk("arst_stall",  32'(stall[1]), 32'd0);
        chk("arst_rdata1", rdata[1],      32'd0);
        chk("arst_rdata0", rdata[0],      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1, "l4_rd_after_rst", 1, 0, 16'd1028, 32'h0, 0, 1, 32'hCAFEF00D);
        issue(0, "l1_rd_after_rst", 1, 0, 16'd1024, 32'h0, 0, 1, 32'hDEADBEEF);

`ifdef DMEM_BYTE_MASK_EN
        be[0] = 4'hF;
        issue(0, "bm_wr_full", 0, 1, 16'd1040, 32'h11223344, 0, 0, 0);
        be[0] = 4'b0101;
        issue(0, "bm_wr_0101", 0, 1, 16'd1040, 32'hAABBCCDD, 0, 0, 0);
        be[0] = 4'hF;
        issue(0, "bm_rd1", 1, 0, 16'd1040, 32'h0, 0, 1, 32'h11BB33DD);
        be[0] = 4'h0;
        issue(0, "bm_wr_none", 0, 1, 16'd1040, 32'hFFFFFFFF, 0, 0, 0);
        be[0] = 4'hF;
        issue(0, "bm_rd2", 1, 0, 16'd1040, 32'h0, 0, 1, 32'h11BB33DD);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
